// File: rtl/fifo_read_stream.sv
// Read-side adapter for the async FIFO: pops into a 2-deep buffer and
// presents a valid/ready stream with burst framing and a transfer counter.
module fifo_read_stream #(
    parameter int data_size = 8,
    parameter int burst_len = 4
) (
    input  logic                 read_clk_i,
    input  logic                 read_reset_n_i,
    input  logic                 read_empty_i,
    input  logic [data_size-1:0] read_data_i,
    output logic                 read_increment_o,
    output logic [data_size-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic [15:0]          transfer_count_o
);

    localparam int beat_w = (burst_len > 1) ? $clog2(burst_len) : 1;
    localparam logic [beat_w-1:0] beat_max = beat_w'(burst_len - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [data_size-1:0]  slot0;
    logic [data_size-1:0]  slot1;
    logic [data_size-1:0]  slot0_nxt;
    logic [data_size-1:0]  slot1_nxt;
    logic [beat_w-1:0]     beat;
    logic                  push;
    logic                  take;

    // Pop only from local state, so out_ready_i never reaches the FIFO side.
    assign push             = read_reset_n_i && !read_empty_i && (state != FULL);
    assign read_increment_o = push;
    assign out_valid_o      = (state != EMPTY);
    assign take             = out_valid_o && out_ready_i;
    assign out_data_o       = slot0;
    assign out_last_o       = out_valid_o && (beat == beat_max);

    // Buffer occupancy and slot movement for the next edge.
    always_comb begin
        state_nxt = state;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    slot0_nxt = read_data_i;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && take) begin
                    slot0_nxt = read_data_i;
                end else if (push) begin
                    slot1_nxt = read_data_i;
                    state_nxt = FULL;
                end else if (take) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    slot0_nxt = slot1;
                    state_nxt = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Buffer state and data registers.
    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_nxt;
            slot0 <= slot0_nxt;
            slot1 <= slot1_nxt;
        end
    end

    // Position of the head word within its burst.
    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            beat <= '0;
        end else if (take) begin
            if (beat == beat_max) begin
                beat <= '0;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Free-running count of accepted transfers, wraps at 2^16.
    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            transfer_count_o <= '0;
        end else if (take) begin
            transfer_count_o <= transfer_count_o + 16'd1;
        end
    end

endmodule
